// File: rtl/mem_pkg.sv
// Shared frame-loader definitions: field widths, parser states and checksum helper.
package mem_pkg;

  localparam int ADDR_W = 16;
  localparam int CNT_W  = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    S_ADDR_LO,
    S_ADDR_HI,
    S_CNT_LO,
    S_CNT_HI,
    S_DATA_LO,
    S_DATA_HI,
    S_CSUM
  } state_t;

  // A frame is good when the running sum plus the checksum byte wraps to zero.
  function automatic logic csum_bad(input logic [BYTE_W-1:0] sum,
                                    input logic [BYTE_W-1:0] csum);
    logic [BYTE_W-1:0] total;
    total = sum + csum;
    return (total != '0);
  endfunction

endpackage

// File: rtl/mem_loader.sv
// Serial frame loader: parses address/count/data/checksum bytes and writes
// 16-bit words into sram, reporting completion and checksum errors.
module mem_loader
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic [2*BYTE_W-1:0] mem_wdata_o,
  output logic              mem_wr_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [CNT_W-1:0]    count_q;
  logic [BYTE_W-1:0]   data_lo_q;
  logic [BYTE_W-1:0]   sum_q;
  logic                accept;

  // Two bytes arrive per write at most, so the loader never needs to stall.
  assign in_ready = reset_n;
  assign accept   = in_valid & in_ready;
  assign busy_o   = (state_q != S_ADDR_LO) | mem_wr_o | done_o;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_ADDR_LO;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        S_ADDR_LO: state_d = S_ADDR_HI;
        S_ADDR_HI: state_d = S_CNT_LO;
        S_CNT_LO:  state_d = S_CNT_HI;
        S_CNT_HI:  state_d = ({in_data, count_q[BYTE_W-1:0]} == '0) ? S_CSUM : S_DATA_LO;
        S_DATA_LO: state_d = S_DATA_HI;
        S_DATA_HI: state_d = (count_q == CNT_W'(1)) ? S_CSUM : S_DATA_LO;
        S_CSUM:    state_d = S_ADDR_LO;
        default:   state_d = S_ADDR_LO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= '0;
      count_q     <= '0;
      data_lo_q   <= '0;
      sum_q       <= '0;
      mem_waddr_o <= '0;
      mem_wdata_o <= '0;
      mem_wr_o    <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      mem_wr_o <= 1'b0;
      done_o   <= 1'b0;
      if (accept) begin
        if (state_q != S_CSUM) sum_q <= sum_q + in_data;
        case (state_q)
          S_ADDR_LO: begin
            addr_q[BYTE_W-1:0] <= in_data;
            sum_q              <= in_data;
            err_o              <= 1'b0;
          end
          S_ADDR_HI: addr_q[ADDR_W-1:BYTE_W] <= in_data;
          S_CNT_LO:  count_q[BYTE_W-1:0]     <= in_data;
          S_CNT_HI:  count_q[CNT_W-1:BYTE_W] <= in_data;
          S_DATA_LO: data_lo_q               <= in_data;
          S_DATA_HI: begin
            // Registered write strobe; the address wraps naturally at 16 bits.
            mem_waddr_o <= addr_q;
            mem_wdata_o <= {in_data, data_lo_q};
            mem_wr_o    <= 1'b1;
            addr_q      <= addr_q + 1'b1;
            count_q     <= count_q - 1'b1;
          end
          S_CSUM: begin
            err_o  <= csum_bad(sum_q, in_data);
            done_o <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: stimulus pushes expected writes/done events,
// a negedge monitor pops and compares them.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] mem_waddr_o;
  logic [15:0] mem_wdata_o;
  logic        mem_wr_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  always #5 clk = ~clk;

  mem_loader dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mem_waddr_o (mem_waddr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_wr_o    (mem_wr_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  int   total = 0;
  int   bad   = 0;
  wr_t  wr_q[$];
  logic done_q[$];
  wr_t  mon_wr;
  logic mon_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (mem_wr_o) begin
        if (wr_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                   mem_waddr_o, mem_wdata_o);
        end else begin
          mon_wr = wr_q.pop_front();
          chk("wr_addr", {16'h0, mem_waddr_o}, {16'h0, mon_wr.a});
          chk("wr_data", {16'h0, mem_wdata_o}, {16'h0, mon_wr.d});
        end
      end
      if (done_o) begin
        if (done_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 expected 0");
        end else begin
          mon_err = done_q.pop_front();
          chk("err_at_done", {31'h0, err_o}, {31'h0, mon_err});
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'hxx;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] f[$], input bit gaps);
    foreach (f[i]) send_byte(f[i], gaps ? int'($urandom_range(0, 20)) : 0);
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    wr_q.push_back(w);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_state;
    chk("rst_in_ready", {31'h0, in_ready},    32'h0);
    chk("rst_busy",     {31'h0, busy_o},      32'h0);
    chk("rst_wr",       {31'h0, mem_wr_o},    32'h0);
    chk("rst_waddr",    {16'h0, mem_waddr_o}, 32'h0);
    chk("rst_wdata",    {16'h0, mem_wdata_o}, 32'h0);
    chk("rst_done",     {31'h0, done_o},      32'h0);
    chk("rst_err",      {31'h0, err_o},       32'h0);
  endtask

  initial begin
    int waited;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    idle(3);
    chk_reset_state();
    reset_n = 1'b1;
    idle(1);
    chk("ready_after_rst", {31'h0, in_ready}, 32'h1);
    chk("idle_busy",       {31'h0, busy_o},   32'h0);

    // Good frame: sum of bytes 0x26, checksum 0xDA.
    push_wr(16'h0010, 16'h1234);
    push_wr(16'h0011, 16'h5678);
    done_q.push_back(1'b0);
    send_frame('{8'h10, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hDA}, 1'b0);
    chk("busy_during_done", {31'h0, busy_o}, 32'h1);
    idle(1);
    chk("busy_after_done",  {31'h0, busy_o}, 32'h0);

    // Same frame, checksum off by one: writes still happen, error flagged.
    push_wr(16'h0010, 16'h1234);
    push_wr(16'h0011, 16'h5678);
    done_q.push_back(1'b1);
    send_frame('{8'h10, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hDB}, 1'b0);
    idle(3);
    chk("err_sticky", {31'h0, err_o}, 32'h1);

    // Zero-count frame; its first byte must clear the sticky error.
    done_q.push_back(1'b0);
    send_byte(8'h00, 0);
    chk("err_cleared", {31'h0, err_o}, 32'h0);
    send_frame('{8'h00, 8'h00, 8'h00, 8'h00}, 1'b0);
    idle(2);

    // Address wrap: 0xFFFF then 0x0000; sum 0xAA, checksum 0x56.
    push_wr(16'hFFFF, 16'h2211);
    push_wr(16'h0000, 16'h4433);
    done_q.push_back(1'b0);
    send_frame('{8'hFF, 8'hFF, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h56}, 1'b0);
    idle(2);

    // Reset after the first DATA_LO byte: nothing is written.
    send_frame('{8'h10, 8'h00, 8'h02, 8'h00, 8'h34}, 1'b0);
    reset_n = 1'b0;
    idle(2);
    chk_reset_state();
    reset_n = 1'b1;
    idle(1);

    // Full frame after release, with random gaps between bytes.
    push_wr(16'h0010, 16'h1234);
    push_wr(16'h0011, 16'h5678);
    done_q.push_back(1'b0);
    send_frame('{8'h10, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hDA}, 1'b1);

    waited = 0;
    while ((wr_q.size() != 0 || done_q.size() != 0) && waited < 100) begin
      idle(1);
      waited++;
    end
    chk("pending_writes", wr_q.size(),   32'h0);
    chk("pending_dones",  done_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port in_data  input  8  byte from upstream serial receiver.
REQ-004 SHALL have port in_valid  input  1  in_data valid this cycle.
REQ-005 SHALL have port in_ready  output  1  byte accepted when in_valid and in_ready are both high.
REQ-006 SHALL have port mem_waddr_o  output  16  write word address to sram.
REQ-007 SHALL have port mem_wdata_o  output  16  write data to sram.
REQ-008 SHALL have port mem_wr_o  output  1  single-cycle write strobe to sram.
REQ-009 SHALL have port busy_o  output  1  frame in progress; holds the cpu off memory.
REQ-010 SHALL have port done_o  output  1  one-cycle pulse at frame end.
REQ-011 SHALL have port err_o  output  1  checksum mismatch on last frame; sticky until next frame starts.

Function
REQ-012 SHALL parse the frame: ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, then CNT word pairs (low byte first), then CSUM; all fields little-endian.
REQ-013 SHALL implement states S_ADDR_LO (idle), S_ADDR_HI, S_CNT_LO, S_CNT_HI, S_DATA_LO, S_DATA_HI, S_CSUM; advance one state per accepted byte.
REQ-014 SHALL transition S_CNT_HI -> S_CSUM when the received count is 0, else -> S_DATA_LO.
REQ-015 SHALL transition S_DATA_HI -> S_CSUM when the remaining count reaches 0, else -> S_DATA_LO.
REQ-016 SHALL hold in_ready at 1 in every state; no backpressure, since at most one write per two bytes is needed.
REQ-017 SHALL assert mem_wr_o for exactly one cycle, the cycle after the S_DATA_HI byte is accepted, with mem_waddr_o and mem_wdata_o valid in that same cycle.
REQ-018 SHALL drive all memory outputs from registers, with no combinational path from in_* to mem_*.
REQ-019 SHALL increment the write address by 1 after each write, wrapping 0xFFFF -> 0x0000.
REQ-020 SHALL keep an 8-bit running sum, mod 256, of every byte from ADDR_LO through the last data byte.
REQ-021 SHALL, on the CSUM byte, set err_o = (sum + csum_byte) != 0 mod 256 and pulse done_o the following cycle.
REQ-022 SHALL set busy_o whenever state != S_ADDR_LO, or a write or done pulse is still pending.
REQ-023 SHALL clear err_o and the running sum when ADDR_LO of a new frame is accepted.
REQ-024 SHALL not change state on cycles where in_valid is low; gaps of any length are allowed.
REQ-025 SHALL not back-fill or undo data words already written when the checksum fails; err_o only reports the failure.

Reset
REQ-026 SHALL, while reset_n is low, force: state=S_ADDR_LO, mem_wr_o=0, mem_waddr_o=0, mem_wdata_o=0, busy_o=0, done_o=0, err_o=0, sum=0, count=0.
REQ-027 SHALL, on reset mid-frame, drop the partial frame, issue no further writes, and treat the next byte after release as ADDR_LO.
REQ-028 SHALL drive in_ready=0 while reset_n is low.

Structure
REQ-029 SHALL place the state enum and the frame-field width constants (ADDR_W=16, CNT_W=16, BYTE_W=8) in the shared package mem_pkg.
REQ-030 SHALL keep the block as a single module with no sub-modules; it instantiates beside sram and muxes onto the sram write port while busy_o is high.

Verification
REQ-031 Bytes 10 00 02 00 34 12 78 56 + correct csum -> writes 0x0010=0x1234, 0x0011=0x5678; done_o pulses; err_o=0.
REQ-032 Same frame with csum off by 1 -> both writes still occur; err_o=1 after done_o; err_o clears on the next frame's first byte.
REQ-033 Count=0 frame (00 00 00 00 + csum 00) -> no mem_wr_o; done_o pulses; err_o=0.
REQ-034 Base address 0xFFFF, count 2 -> writes to 0xFFFF then 0x0000.
REQ-035 reset_n low after DATA_LO of the first word -> no write; a full frame sent after release loads correctly.
REQ-036 Random in_valid gaps of 0-20 cycles between bytes -> write sequence identical to the gap-free case.
